// File: rtl/shared_adder_scheduler.sv
// Purpose: round-robin scheduler sharing one N-bit carry-select adder among NREQ requesters, with chained multi-beat ops.
// Latency: 1 cycle from req_valid&&req_ready to res_valid; one op per cycle when res_ready is held high.
// Backpressure: req_ready is all zero while a result is pending and res_ready is low. Optional res_ovf via SHARED_ADDER_OVF_EN.

// Single-bit full adder cell used to build the shared datapath.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

module shared_adder_scheduler #(
    parameter int N    = 8,
    parameter int NREQ = 4,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    input  logic [NREQ-1:0]   req_chain,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [N-1:0]      res_sum,
    output logic              res_cout,
    output logic [IDW-1:0]    res_id
`ifdef SHARED_ADDER_OVF_EN
    ,
    output logic              res_ovf
`endif
);

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, owner_q;
    logic           carry_q;
    logic           res_valid_q;
    logic [N-1:0]   res_sum_q;
    logic           res_cout_q;
    logic [IDW-1:0] res_id_q;

    logic           can_accept;
    logic           hi_found, lo_found;
    logic [IDW-1:0] hi_idx, lo_idx;
    logic [IDW-1:0] sel_idx;
    logic           sel_en;
    logic [N-1:0]   op_a, op_b;
    logic           sel_cin, sel_chain;
    logic           add_cin;
    logic [N-1:0]   add_sum;
    logic           add_cout;
    logic           xfer;

    // A new op may enter whenever the result register is empty or draining this cycle.
    assign can_accept = !res_valid_q || res_ready;
    assign xfer       = |(req_valid & req_ready);

    // Round-robin search: lowest valid index at/after ptr, else lowest valid overall (wrap).
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = IDW'(i);
                if (i >= int'(ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = IDW'(i);
                end
            end
        end
    end

    // FSM state register; reset drops any chain in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a chained beat locks the adder to its owner until a non-chained beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (xfer && sel_chain)  state_d = S_LOCKED;
            S_LOCKED: if (xfer && !sel_chain) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs: pick the granted requester, its carry source, and the one-hot ready.
    always_comb begin
        sel_idx = hi_found ? hi_idx : lo_idx;
        sel_en  = lo_found;
        add_cin = sel_cin;
        if (state_q == S_LOCKED) begin
            sel_idx = owner_q;
            sel_en  = 1'b1;
            add_cin = carry_q;
        end
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = sel_en && can_accept && !rst && (sel_idx == IDW'(i));
        end
    end

    // Operand mux feeding the single shared adder.
    always_comb begin
        op_a      = '0;
        op_b      = '0;
        sel_cin   = 1'b0;
        sel_chain = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel_idx == IDW'(i)) begin
                op_a      = req_a[i*N +: N];
                op_b      = req_b[i*N +: N];
                sel_cin   = req_cin[i];
                sel_chain = req_chain[i];
            end
        end
    end

    // Carry-select adder: low half ripples, high half is precomputed for both carries and muxed.
    localparam int LW = (N + 1) / 2;
    localparam int HW = N - LW;

    logic [LW:0] lo_c;
    assign lo_c[0] = add_cin;

    genvar g;
    generate
        for (g = 0; g < LW; g++) begin : g_lo
            full_adder u_fa (
                .a_i (op_a[g]),
                .b_i (op_b[g]),
                .ci_i(lo_c[g]),
                .s_o (add_sum[g]),
                .co_o(lo_c[g+1])
            );
        end
        if (HW > 0) begin : g_hi
            logic [HW:0]   c0, c1;
            logic [HW-1:0] s0, s1;
            assign c0[0] = 1'b0;
            assign c1[0] = 1'b1;
            for (g = 0; g < HW; g++) begin : g_bit
                full_adder u_fa0 (
                    .a_i (op_a[LW+g]),
                    .b_i (op_b[LW+g]),
                    .ci_i(c0[g]),
                    .s_o (s0[g]),
                    .co_o(c0[g+1])
                );
                full_adder u_fa1 (
                    .a_i (op_a[LW+g]),
                    .b_i (op_b[LW+g]),
                    .ci_i(c1[g]),
                    .s_o (s1[g]),
                    .co_o(c1[g+1])
                );
            end
            assign add_sum[N-1:LW] = lo_c[LW] ? s1 : s0;
            assign add_cout        = lo_c[LW] ? c1[HW] : c0[HW];
        end else begin : g_nohi
            assign add_cout = lo_c[LW];
        end
    endgenerate

    // Result register, chain carry, lock owner and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_cout_q  <= 1'b0;
            res_id_q    <= '0;
            carry_q     <= 1'b0;
            owner_q     <= '0;
            ptr_q       <= '0;
        end else if (xfer) begin
            res_valid_q <= 1'b1;
            res_sum_q   <= add_sum;
            res_cout_q  <= add_cout;
            res_id_q    <= sel_idx;
            carry_q     <= add_cout;
            owner_q     <= sel_idx;
            if (!sel_chain) begin
                ptr_q <= (sel_idx == IDW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
            end
        end else if (res_ready) begin
            res_valid_q <= 1'b0;
        end
    end

    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_cout  = res_cout_q;
    assign res_id    = res_id_q;

`ifdef SHARED_ADDER_OVF_EN
    logic res_ovf_q;
    logic ovf_d;

    assign ovf_d = (op_a[N-1] == op_b[N-1]) && (add_sum[N-1] != op_a[N-1]);

    // Signed overflow flag, captured and held alongside the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_ovf_q <= 1'b0;
        end else if (xfer) begin
            res_ovf_q <= ovf_d;
        end
    end

    assign res_ovf = res_ovf_q;
`endif

endmodule

// File: tb/tb_shared_adder_scheduler.sv
// Directed bench for shared_adder_scheduler with N=8, NREQ=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled away from the edge.
// Covers reset, round-robin, chained locking, backpressure, reset mid-chain and optional overflow.
module tb_shared_adder_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_cin;
    logic [3:0]  req_chain;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_sum;
    logic        res_cout;
    logic [1:0]  res_id;
`ifdef SHARED_ADDER_OVF_EN
    logic        res_ovf;
`endif

    int total = 0;
    int bad   = 0;

    shared_adder_scheduler #(.N(8), .NREQ(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_cin  (req_cin),
        .req_chain(req_chain),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_sum  (res_sum),
        .res_cout (res_cout),
        .res_id   (res_id)
`ifdef SHARED_ADDER_OVF_EN
        ,
        .res_ovf  (res_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i, input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic chain);
        req_valid[i]     = v;
        req_a[i*8 +: 8]  = a;
        req_b[i*8 +: 8]  = b;
        req_cin[i]       = cin;
        req_chain[i]     = chain;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input logic [7:0] s, input logic c, input logic [1:0] id);
        check({tag, "_valid"}, 32'(res_valid), 32'd1);
        check({tag, "_sum"},   32'(res_sum),   32'(s));
        check({tag, "_cout"},  32'(res_cout),  32'(c));
        check({tag, "_id"},    32'(res_id),    32'(id));
    endtask

    initial begin
        int g;
        logic [7:0] ea;

        rst       = 1'b1;
        res_ready = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        req_chain = '0;
        for (int k = 0; k < 4; k++) begin
            ea = 8'(8'h11 * (k + 1));
            drive(k, 1'b1, ea, 8'h01, 1'b0, 1'b0);
        end

        // reset state, with all requesters already valid
        #3;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_sum",   32'(res_sum),   32'd0);
        check("rst_cout",  32'(res_cout),  32'd0);
        check("rst_id",    32'(res_id),    32'd0);
`ifdef SHARED_ADDER_OVF_EN
        check("rst_ovf",   32'(res_ovf),   32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // round robin across all four, then back to 0
        for (int k = 0; k < 5; k++) begin
            g  = k % 4;
            ea = 8'(8'h11 * (g + 1) + 1);
            check($sformatf("rr_ready%0d", k), 32'(req_ready), 32'(1 << g));
            tick();
            chk_res($sformatf("rr%0d", k), ea, 1'b0, 2'(g));
        end
        req_valid = '0;
        tick();
        check("drain_valid", 32'(res_valid), 32'd0);

        // single op from requester 0 (pointer at 1 wraps to 0)
        drive(0, 1'b1, 8'h0F, 8'h01, 1'b0, 1'b0);
        #1;
        check("one_ready", 32'(req_ready), 32'b0001);
        tick();
        chk_res("one", 8'h10, 1'b0, 2'd0);
        req_valid = '0;

        // requester 1 op moves pointer to 2; requester 1 then stays valid
        drive(1, 1'b1, 8'h05, 8'h05, 1'b0, 1'b0);
        #1;
        check("r1_ready", 32'(req_ready), 32'b0010);
        tick();
        chk_res("r1", 8'h0A, 1'b0, 2'd1);

        // chained pair from requester 2 while requester 1 waits
        drive(2, 1'b1, 8'hFF, 8'h01, 1'b0, 1'b1);
        #1;
        check("ch1_ready", 32'(req_ready), 32'b0100);
        tick();
        chk_res("ch1", 8'h00, 1'b1, 2'd2);
        drive(2, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        #1;
        check("ch_gap_ready", 32'(req_ready), 32'b0100);
        tick();
        check("ch_gap_valid", 32'(res_valid), 32'd0);
        drive(2, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0);
        #1;
        check("ch2_ready", 32'(req_ready), 32'b0100);
        tick();
        chk_res("ch2", 8'h01, 1'b0, 2'd2);
        drive(2, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        #1;
        check("after_ch_ready", 32'(req_ready), 32'b0010);
        tick();
        chk_res("after_ch", 8'h0A, 1'b0, 2'd1);
        req_valid = '0;

        // backpressure: result held, no grants while res_ready low
        drive(0, 1'b1, 8'h20, 8'h03, 1'b0, 1'b0);
        #1;
        check("bp_ready0", 32'(req_ready), 32'b0001);
        tick();
        chk_res("bp_load", 8'h23, 1'b0, 2'd0);
        res_ready = 1'b0;
        drive(0, 1'b1, 8'h40, 8'h04, 1'b0, 1'b0);
        drive(3, 1'b1, 8'h30, 8'h30, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp_ready%0d", k), 32'(req_ready), 32'd0);
            tick();
            chk_res($sformatf("bp_hold%0d", k), 8'h23, 1'b0, 2'd0);
        end
        res_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'b1000);
        tick();
        chk_res("bp_release", 8'h60, 1'b0, 2'd3);
        req_valid = '0;
        tick();

        // reset between chained beats of requester 3
        drive(3, 1'b1, 8'h80, 8'h80, 1'b0, 1'b1);
        #1;
        check("rc1_ready", 32'(req_ready), 32'b1000);
        tick();
        chk_res("rc1", 8'h00, 1'b1, 2'd3);
        drive(3, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("rc_rst_valid", 32'(res_valid), 32'd0);
        check("rc_rst_ready", 32'(req_ready), 32'd0);
        check("rc_rst_sum",   32'(res_sum),   32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rc_post_valid", 32'(res_valid), 32'd0);
        drive(1, 1'b1, 8'h01, 8'h01, 1'b1, 1'b0);
        #1;
        check("rc_new_ready", 32'(req_ready), 32'b0010);
        tick();
        chk_res("rc_new", 8'h03, 1'b0, 2'd1);
        req_valid = '0;

`ifdef SHARED_ADDER_OVF_EN
        // signed overflow flag
        drive(0, 1'b1, 8'h7F, 8'h01, 1'b0, 1'b0);
        tick();
        chk_res("ovf_a", 8'h80, 1'b0, 2'd0);
        check("ovf_a_flag", 32'(res_ovf), 32'd1);
        drive(0, 1'b1, 8'h80, 8'h80, 1'b0, 1'b0);
        tick();
        chk_res("ovf_b", 8'h00, 1'b1, 2'd0);
        check("ovf_b_flag", 32'(res_ovf), 32'd1);
        drive(0, 1'b1, 8'h10, 8'h20, 1'b0, 1'b0);
        tick();
        chk_res("ovf_c", 8'h30, 1'b0, 2'd0);
        check("ovf_c_flag", 32'(res_ovf), 32'd0);
        req_valid = '0;
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
